vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Raster timing source that feeds the pattern generators (checkerboard etc.).
//   Produces the pixel coordinates x/y, the active flag, the once-per-frame next_frame
//   strobe, and hsync/vsync for the VGA connector.
//   Sits between the top-level clock/reset and every pattern_* block.
//   The pattern blocks consume x/y/active combinationally and update motion state on next_frame.
// PARAMETERS
//   H_ACTIVE 640  visible pixels per line
//   H_FRONT  16   horizontal front porch, pixels
//   H_SYNC   96   horizontal sync width, pixels
//   H_BACK   48   horizontal back porch, pixels (H_TOTAL = 800)
//   V_ACTIVE 480  visible lines per frame
//   V_FRONT  10   vertical front porch, lines
//   V_SYNC   2    vertical sync width, lines
//   V_BACK   33   vertical back porch, lines (V_TOTAL = 525)
//   SYNC_POL 0    sync asserted level (0 = active-low, as 640x480@60)
//   CLK_DIV  1    clk cycles per pixel tick (1..4); 1 = clk is the pixel clock
// PORTS
//   clk         in  1   system clock
//   rst         in  1   asynchronous, active-high reset
//   x           out 10  current pixel column, 0..H_TOTAL-1
//   y           out 10  current line, 0..V_TOTAL-1
//   active      out 1   1 when x<H_ACTIVE and y<V_ACTIVE
//   hsync       out 1   horizontal sync, level per SYNC_POL
//   vsync       out 1   vertical sync, level per SYNC_POL
//   next_frame  out 1   one-clk strobe at start of vertical blank
//   frame_count out 8   frames completed, wraps 255->0
// BEHAVIOUR
//   - Reset (async, rst=1): x=0, y=0, active=1, hsync=vsync=~SYNC_POL,
//     next_frame=0, frame_count=0, divider=0. First tick after rst release -> x=1.
//   - Pixel tick: internal divider counts 0..CLK_DIV-1; tick when it equals CLK_DIV-1
//     (every clk when CLK_DIV=1). Counters change only on a tick.
//   - Tick: x -> x+1; at x=H_TOTAL-1, x -> 0 and y advances;
//     y=V_TOTAL-1 with x wrap -> y=0. Simultaneous x and y wrap is the frame boundary.
//   - All outputs are registers loaded from decode of the NEXT counter values, so
//     active/hsync/vsync are always aligned to the x/y presented in the same cycle.
//     There is no extra pipeline skew.
//   - hsync = SYNC_POL when H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC, else ~SYNC_POL.
//     vsync uses the same rule on y with V_* parameters.
//   - next_frame: high for exactly one clk (not CLK_DIV clks) on the tick where the
//     counters move to x=0, y=V_ACTIVE.
//     - Gives consumers a whole blanking interval to update offsets.
//     - Never asserted during active video.
//   - frame_count increments on the same clk as next_frame; 8-bit modular wrap.
//   - Arithmetic: counters are 10-bit unsigned. H_TOTAL and V_TOTAL must be <= 1024;
//     elaboration fails via generate-time check otherwise.
//   - Reset mid-frame returns all state to the reset values immediately
//     (async), with no partial-line completion.
// STRUCTURE
//   - Shared package vga_timing_pkg:
//     - 640x480@60 default constants (H_*/V_*);
//     - derived H_TOTAL/V_TOTAL/H_SYNC_START/H_SYNC_END/V_SYNC_START/V_SYNC_END;
//     - COORD_W=10.
//   - One sub-module is natural: wrap_counter.
//     - Interface: (clk, rst, en, max) -> (count, wrap).
//     - Instantiated twice: horizontal with en=tick; vertical with en=tick&h_wrap.
//   - Divider, decode and output registers stay in the top module.
// TESTING
//   1. Reset then 800*525 ticks (CLK_DIV=1):
//      - x/y return to 0,0 exactly at clk 420000;
//      - exactly one next_frame pulse, at x=0,y=480;
//      - frame_count=1.
//   2. Line timing:
//      - hsync low for x in 656..751 inclusive, high at x=655 and 752;
//      - active=0 for x>=640, active=1 at x=639,y=0.
//   3. Frame timing:
//      - vsync low exactly on lines 490 and 491;
//      - active=0 on all of lines 480..524.
//   4. CLK_DIV=2:
//      - x advances every 2nd clk;
//      - next_frame width = 1 clk;
//      - frame period 840000 clks.
//   5. Async reset asserted at x=300,y=200 between clk edges:
//      - outputs reach reset values before the next edge;
//      - counting restarts from 0,0.
//   6. frame_count wrap:
//      - run 256 frames -> frame_count reads 0 after pulse 256;
//      - next_frame count=256.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the VGA timing source and its consumers.
// 640x480@60 defaults, derived totals/sync windows, coordinate width and a
// half-open window decode helper.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned FRAME_W = 8;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FRONT  = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BACK   = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FRONT  = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BACK   = 33;

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    // True when lo <= v < hi.
    function automatic logic in_window(input logic [COORD_W-1:0] v,
                                       input int unsigned lo,
                                       input int unsigned hi);
        return (32'(v) >= lo) && (32'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle from the timing source to the pattern generators.
// master: timing source drives everything; slave: consumers read everything.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               active;
    logic               hsync;
    logic               vsync;
    logic               next_frame;
    logic [FRAME_W-1:0] frame_count;

    modport master (output x, y, active, hsync, vsync, next_frame, frame_count);
    modport slave  (input  x, y, active, hsync, vsync, next_frame, frame_count);
endinterface

// File: rtl/vga_timing_gen_wrap_counter.sv
// Enabled up-counter that wraps from max_i to 0.
// Ports: clk, rst (async active-high), en_i, max_i -> count_o (registered),
//        wrap_c_o (combinational: enabled and currently at max_i).
module wrap_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned W = COORD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] count_o,
    output logic         wrap_c_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign wrap_c_o = en_i && (count_q == max_i);

    always_comb begin
        count_d = count_q;
        if (wrap_c_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel divider, x/y counters, and registered decode of
// active/hsync/vsync/next_frame/frame_count aligned to the presented x/y.
// Ports: clk, rst (async active-high), vga (master modport of vga_timing_gen_if).
module vga_timing_gen
    import vga_timing_pkg::COORD_W, vga_timing_pkg::FRAME_W, vga_timing_pkg::in_window;
#(
    parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FRONT  = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK   = vga_timing_pkg::H_BACK,
    parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FRONT  = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK   = vga_timing_pkg::V_BACK,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned CLK_DIV  = 1
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_LO   = H_ACTIVE + H_FRONT;
    localparam int unsigned HS_HI   = HS_LO + H_SYNC;
    localparam int unsigned VS_LO   = V_ACTIVE + V_FRONT;
    localparam int unsigned VS_HI   = VS_LO + V_SYNC;
    localparam int unsigned DIV_W   = 2;

    // Elaboration guards on the configuration.
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if ((CLK_DIV == 0) || (CLK_DIV > 4)) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be 1..4");
    end

    // Pixel-tick divider.
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_c;

    assign tick_c = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (tick_c) begin
            div_d = '0;
        end
    end

    // Raster counters.
    logic [COORD_W-1:0] x_cnt;
    logic [COORD_W-1:0] y_cnt;
    logic               h_wrap_c;
    logic               v_wrap_c;
    logic               v_en_c;

    assign v_en_c = tick_c && h_wrap_c;

    wrap_counter #(.W(COORD_W)) u_h_cnt (
        .clk      (clk),
        .rst      (rst),
        .en_i     (tick_c),
        .max_i    (COORD_W'(H_TOTAL - 1)),
        .count_o  (x_cnt),
        .wrap_c_o (h_wrap_c)
    );

    wrap_counter #(.W(COORD_W)) u_v_cnt (
        .clk      (clk),
        .rst      (rst),
        .en_i     (v_en_c),
        .max_i    (COORD_W'(V_TOTAL - 1)),
        .count_o  (y_cnt),
        .wrap_c_o (v_wrap_c)
    );

    // Values the counters will hold after this edge; decode uses these so the
    // registered flags line up with the x/y presented in the same cycle.
    logic [COORD_W-1:0] x_nxt_c;
    logic [COORD_W-1:0] y_nxt_c;

    always_comb begin
        x_nxt_c = x_cnt;
        y_nxt_c = y_cnt;
        if (h_wrap_c) begin
            x_nxt_c = '0;
        end else if (tick_c) begin
            x_nxt_c = x_cnt + COORD_W'(1);
        end
        if (v_wrap_c) begin
            y_nxt_c = '0;
        end else if (v_en_c) begin
            y_nxt_c = y_cnt + COORD_W'(1);
        end
    end

    // Counters step into x=0, y=V_ACTIVE: start of vertical blank.
    logic next_frame_d;
    assign next_frame_d = v_en_c && (y_cnt == COORD_W'(V_ACTIVE - 1));

    logic               active_q;
    logic               hsync_q;
    logic               vsync_q;
    logic               next_frame_q;
    logic [FRAME_W-1:0] frame_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q        <= '0;
            active_q     <= 1'b1;
            hsync_q      <= ~SYNC_POL;
            vsync_q      <= ~SYNC_POL;
            next_frame_q <= 1'b0;
            frame_q      <= '0;
        end else begin
            div_q        <= div_d;
            active_q     <= (32'(x_nxt_c) < H_ACTIVE) && (32'(y_nxt_c) < V_ACTIVE);
            hsync_q      <= in_window(x_nxt_c, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
            vsync_q      <= in_window(y_nxt_c, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
            next_frame_q <= next_frame_d;
            if (next_frame_d) begin
                frame_q <= frame_q + FRAME_W'(1);
            end
        end
    end

    assign vga.x           = x_cnt;
    assign vga.y           = y_cnt;
    assign vga.active      = active_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.next_frame  = next_frame_q;
    assign vga.frame_count = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance, a reduced-raster
// instance (15x10) and a reduced-raster CLK_DIV=2 / positive-sync instance,
// all compared every clock against an arithmetic raster model.
module tb_vga_timing_gen;

    // Reduced raster: H 8/2/3/2 = 15, V 6/1/2/1 = 10, 150 ticks per frame.
    localparam int unsigned S_HA = 8,  S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int unsigned S_VA = 6,  S_VF = 1, S_VS = 2, S_VB = 1;
    localparam int unsigned S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int unsigned S_VT = S_VA + S_VF + S_VS + S_VB;
    localparam int unsigned S_FR = S_HT * S_VT;
    localparam int unsigned N_MAIN = 256 * S_FR + 101;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned pulses1  = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if if0 ();
    vga_timing_gen_if if1 ();
    vga_timing_gen_if if2 ();

    vga_timing_gen dut0 (.clk(clk), .rst(rst0), .vga(if0));

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .SYNC_POL(1'b0), .CLK_DIV(1)
    ) dut1 (.clk(clk), .rst(rst1), .vga(if1));

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .SYNC_POL(1'b1), .CLK_DIV(2)
    ) dut2 (.clk(clk), .rst(rst2), .vga(if2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected raster state after t pixel ticks; new_tick says a tick landed
    // on the last edge (next_frame is one clk wide).
    task automatic chk_raster(input string name, input int unsigned t, input bit new_tick,
                              input int unsigned ha, input int unsigned hf,
                              input int unsigned hs, input int unsigned hb,
                              input int unsigned va, input int unsigned vf,
                              input int unsigned vs, input int unsigned vb,
                              input bit pol,
                              input logic [9:0] x, input logic [9:0] y,
                              input logic act, input logic hsy, input logic vsy,
                              input logic nf, input logic [7:0] fc);
        int unsigned ht, vt, fr, pos, ex, ey, frames;
        bit e_act, e_hs, e_vs, e_nf;
        ht     = ha + hf + hs + hb;
        vt     = va + vf + vs + vb;
        fr     = ht * vt;
        pos    = t % fr;
        ex     = pos % ht;
        ey     = pos / ht;
        e_act  = (ex < ha) && (ey < va);
        e_hs   = ((ex >= ha + hf) && (ex < ha + hf + hs)) ? pol : !pol;
        e_vs   = ((ey >= va + vf) && (ey < va + vf + vs)) ? pol : !pol;
        e_nf   = new_tick && (t > 0) && (pos == va * ht);
        frames = (t >= va * ht) ? ((t - va * ht) / fr + 1) : 0;
        chk({name, ".x"},           32'(x),   ex);
        chk({name, ".y"},           32'(y),   ey);
        chk({name, ".active"},      32'(act), 32'(e_act));
        chk({name, ".hsync"},       32'(hsy), 32'(e_hs));
        chk({name, ".vsync"},       32'(vsy), 32'(e_vs));
        chk({name, ".next_frame"},  32'(nf),  32'(e_nf));
        chk({name, ".frame_count"}, 32'(fc),  frames % 256);
    endtask

    task automatic chk0(input int unsigned t, input bit nt);
        chk_raster("dut0", t, nt, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
                   if0.x, if0.y, if0.active, if0.hsync, if0.vsync,
                   if0.next_frame, if0.frame_count);
    endtask

    task automatic chk1(input int unsigned t, input bit nt);
        chk_raster("dut1", t, nt, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b0,
                   if1.x, if1.y, if1.active, if1.hsync, if1.vsync,
                   if1.next_frame, if1.frame_count);
    endtask

    task automatic chk2(input int unsigned t, input bit nt);
        chk_raster("dut2", t, nt, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1,
                   if2.x, if2.y, if2.active, if2.hsync, if2.vsync,
                   if2.next_frame, if2.frame_count);
    endtask

    initial begin
        // Reset values while rst is held.
        @(negedge clk);
        chk0(0, 1'b0);
        chk1(0, 1'b0);
        chk2(0, 1'b0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        rst2 = 1'b0;

        // Free run: 256 reduced frames plus part of the next one.
        for (int n = 1; n <= int'(N_MAIN); n++) begin
            @(negedge clk);
            if (if1.next_frame === 1'b1) pulses1++;
            chk0(n, 1'b1);
            chk1(n, 1'b1);
            chk2(n / 2, (n % 2) == 0);
            if (n == int'(256 * S_FR)) begin
                chk("dut1.pulses_after_256_frames", pulses1, 256);
                chk("dut1.frame_count_wrapped", 32'(if1.frame_count), 0);
            end
        end

        // dut1 now sits at x=11, y=6 with frame_count=1; reset between edges.
        #2;
        rst1 = 1'b1;
        #1;
        chk1(0, 1'b0);
        @(negedge clk);
        chk1(0, 1'b0);
        rst1 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk1(k, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
